divider: RTL

Multi-cycle 32-bit integer divider for the NPC execute stage, implementing RISC-V DIV/DIVU/REM/REMU semantics. It uses a radix-2 restoring algorithm with one quotient bit per cycle and a 33-bit trial subtraction. It accepts one operation at a time through a valid/ready handshake and returns quotient and remainder together through a second valid/ready handshake. It sits beside the single-cycle adder/subtractor in the ALU, and the execute stage stalls on it.

---
 rtl/divider.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/divider.sv
// rtl/divider.sv - multi-cycle radix-2 restoring 32-bit divider (DIV/DIVU/REM/REMU); optional DIVIDER_FAST_SPECIAL_EN
module divider (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        div_valid_i,
    output logic        div_ready_o,
    input  logic [31:0] div_dividend_i,
    input  logic [31:0] div_divisor_i,
    input  logic        div_signed_i,
    input  logic        div_flush_i,
    output logic        div_out_valid_o,
    input  logic        div_out_ready_i,
    output logic [31:0] div_quotient_o,
    output logic [31:0] div_remainder_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;       // partial remainder
    logic [31:0] dvd_q, dvd_d;       // dividend shifts out, quotient shifts in
    logic [31:0] dvs_q, dvs_d;       // divisor magnitude
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        div0_q, div0_d;
    logic        ovf_q, ovf_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] quo_out_q, quo_out_d;
    logic [31:0] rem_out_q, rem_out_d;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        in_div0, in_ovf;
    logic [32:0] partial, trial;
    logic [31:0] q_fix, r_fix;

    // Operand magnitudes and special-case detection on the request inputs.
    // Two's-complement negate of 0x80000000 yields 0x80000000, which is the
    // correct unsigned magnitude, so no overflow handling is needed here.
    always_comb begin
        a_neg   = div_signed_i & div_dividend_i[31];
        b_neg   = div_signed_i & div_divisor_i[31];
        a_mag   = a_neg ? (~div_dividend_i + 32'd1) : div_dividend_i;
        b_mag   = b_neg ? (~div_divisor_i + 32'd1) : div_divisor_i;
        in_div0 = (div_divisor_i == 32'd0);
        in_ovf  = div_signed_i & (div_dividend_i == 32'h8000_0000)
                  & (div_divisor_i == 32'hFFFF_FFFF);
    end

    // One restoring iteration: 33-bit trial subtraction of the divisor.
    always_comb begin
        partial = {rem_q, dvd_q[31]};
        trial   = partial - {1'b0, dvs_q};
        q_fix   = q_neg_q ? (~dvd_q + 32'd1) : dvd_q;
        r_fix   = r_neg_q ? (~rem_q + 32'd1) : rem_q;
    end

    // Next-state and datapath update for the IDLE/BUSY/FIX/DONE sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        div0_d      = div0_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        quo_out_d   = quo_out_q;
        rem_out_d   = rem_out_q;

        if (div_flush_i) begin
            state_d     = S_IDLE;
            cnt_d       = 6'd0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (div_valid_i) begin
                        rem_d   = 32'd0;
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        div0_d  = in_div0;
                        ovf_d   = in_ovf;
                        cnt_d   = 6'd0;
                        state_d = S_BUSY;
`ifdef DIVIDER_FAST_SPECIAL_EN
                        if (in_div0) begin
                            quo_out_d   = 32'hFFFF_FFFF;
                            rem_out_d   = div_dividend_i;
                            out_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end else if (in_ovf) begin
                            quo_out_d   = 32'h8000_0000;
                            rem_out_d   = 32'd0;
                            out_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end
`endif
                    end
                end
                S_BUSY: begin
                    if (!trial[32]) begin
                        rem_d = trial[31:0];
                    end else begin
                        rem_d = partial[31:0];
                    end
                    dvd_d = {dvd_q[30:0], ~trial[32]};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    // Divide-by-zero remainder falls out of the iteration as the
                    // dividend; only the quotient needs forcing.
                    quo_out_d = q_fix;
                    rem_out_d = r_fix;
                    if (div0_q) begin
                        quo_out_d = 32'hFFFF_FFFF;
                    end else if (ovf_q) begin
                        quo_out_d = 32'h8000_0000;
                        rem_out_d = 32'd0;
                    end
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
                S_DONE: begin
                    if (div_out_ready_i) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 6'd0;
            rem_q       <= 32'd0;
            dvd_q       <= 32'd0;
            dvs_q       <= 32'd0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            quo_out_q   <= 32'd0;
            rem_out_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            div0_q      <= div0_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            quo_out_q   <= quo_out_d;
            rem_out_q   <= rem_out_d;
        end
    end

    assign div_ready_o     = (state_q == S_IDLE);
    assign div_out_valid_o = out_valid_q;
    assign div_quotient_o  = quo_out_q;
    assign div_remainder_o = rem_out_q;

endmodule
